apb_rr_arbiter: RTL and testbench
=================================

Name: apb_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream APB4 completer between NumReq upstream APB4 requesters.
- Each requester connects as if to a completer. The arbiter grants one requester at a time and replays its transfer on a single APB4 manager port.
- Sits between requester-side APB interfaces and a single register-file or peripheral completer.

Parameters:
- NumReq, 2, number of upstream requesters (>=1).
- AddrWidth, 32, paddr width.
- DataWidth, 32, pwdata/prdata width.
- StrbWidth, ceil(DataWidth/8), pstrb width (derived; not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_paddr_i  in  NumReq*AddrWidth  per-requester paddr, requester i at slice i
- req_pprot_i  in  NumReq*3  per-requester pprot
- req_psel_i  in  NumReq  per-requester psel
- req_penable_i  in  NumReq  per-requester penable
- req_pwrite_i  in  NumReq  per-requester pwrite
- req_pwdata_i  in  NumReq*DataWidth  per-requester pwdata
- req_pstrb_i  in  NumReq*StrbWidth  per-requester pstrb
- req_pready_o  out  NumReq  per-requester pready
- req_prdata_o  out  NumReq*DataWidth  per-requester prdata
- req_pslverr_o  out  NumReq  per-requester pslverr
- paddr_o  out  AddrWidth  downstream paddr
- pprot_o  out  3  downstream pprot
- psel_o  out  1  downstream psel
- penable_o  out  1  downstream penable
- pwrite_o  out  1  downstream pwrite
- pwdata_o  out  DataWidth  downstream pwdata
- pstrb_o  out  StrbWidth  downstream pstrb
- pready_i  in  1  downstream pready
- prdata_i  in  DataWidth  downstream prdata
- pslverr_i  in  1  downstream pslverr

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Registered state:
  - FSM with states IDLE, SETUP, ACCESS.
  - grant index (clog2(NumReq) bits, min 1).
  - round-robin pointer rr_q, same width.
- Reset values:
  - state=IDLE, grant=0, rr_q=0.
  - psel_o=0, penable_o=0, all other downstream outputs 0.
  - req_pready_o=0, req_prdata_o=0, req_pslverr_o=0.
  - Reset asserted mid-transfer aborts the transfer in that cycle. No response is returned to the requester.
- Eligibility: requester i is pending when req_psel_i[i]=1, whatever the value of req_penable_i[i].
- IDLE:
  - If any requester is pending, choose the first pending index starting at rr_q, ascending and wrapping modulo NumReq.
  - Register the choice in grant and go to SETUP.
  - If nothing is pending, stay in IDLE.
- SETUP:
  - psel_o=1, penable_o=0.
  - paddr/pprot/pwrite/pwdata/pstrb are driven combinationally from requester[grant].
  - Always go to ACCESS next cycle.
- ACCESS:
  - psel_o=1, penable_o=1, downstream signals still muxed from requester[grant].
  - While pready_i=0, stay in ACCESS (wait states).
  - When pready_i=1:
    - Same cycle: req_pready_o[grant]=1, req_prdata_o[grant]=prdata_i, req_pslverr_o[grant]=pslverr_i.
    - Next cycle: state goes to IDLE and rr_q becomes (grant+1) mod NumReq.
- Response outputs:
  - All non-granted requesters see pready=0, prdata=0, pslverr=0 at all times.
  - The granted requester sees pready=0 outside the completing ACCESS cycle.
- Idle outputs: in IDLE, all downstream outputs are 0. No X or requester data leaks downstream.
- Latency:
  - Requester setup at cycle 0 (arbiter in IDLE) gives downstream SETUP at cycle 1 and ACCESS at cycle 2.
  - With zero wait states, completion is at cycle 2.
  - Minimum period between transfers is 3 cycles (one IDLE cycle between grants).
- Fairness: the requester just served has lowest priority in the next arbitration. No requester waits more than NumReq-1 other transfers.
- Simultaneous events:
  - A requester that completes and immediately asserts a new setup is seen as pending in the following IDLE cycle, subject to round-robin.
  - A new request arriving while another transfer is in progress is ignored until IDLE.
- Protocol violations:
  - Granted requester deasserting psel, or changing addr/data, before completion is not supported.
  - The bench flags it with an assertion. The RTL keeps sequencing with the live muxed values.
- NumReq=1: grant and rr_q are constant 0, and the FSM behaves identically.
- Arithmetic: the rr_q increment wraps modulo NumReq, and NumReq need not be a power of two.

Test Plan:
- Single requester 0 write, addr 0x1000, data 0xDEADBEEF, strb 0xF, pready_i tied 1:
  - Downstream SETUP at cycle 1, ACCESS at cycle 2.
  - req_pready_o[0]=1 at cycle 2. No other requester pready.
- Requesters 0 and 1 both assert psel at cycle 0, rr_q=0:
  - Requester 0 is served first, completing at cycle 2.
  - Requester 1 gets SETUP at cycle 4 and completes at cycle 5; rr_q ends at 0.
- Read from requester 1 with 3 wait states, prdata_i=0xA5A5_0001 on the ready cycle:
  - req_pready_o[1] rises only on that cycle, with req_prdata_o[1]=0xA5A5_0001.
  - Requester 0 outputs stay 0.
- pslverr_i=1 on completion of a write by requester 2 (NumReq=3): req_pslverr_o[2]=1 for exactly one cycle.
- All 3 requesters continuously pending for 9 transfers: grant order is 0,1,2,0,1,2,0,1,2.
- rst_i asserted during ACCESS with pready_i=0: next cycle psel_o=0, penable_o=0, all req_pready_o=0, state IDLE, rr_q=0.

Source files
------------

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB4 completer between NumReq APB4 requesters.
// The granted requester's transfer is replayed downstream as SETUP then ACCESS.
//   state  | meaning
//   IDLE   | nothing in flight; pick next pending requester from rr_q
//   SETUP  | downstream psel=1, penable=0 for requester[grant]
//   ACCESS | downstream psel=1, penable=1; wait for pready_i
module apb_rr_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  localparam int unsigned StrbWidth = (DataWidth + 7) / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq*AddrWidth-1:0]    req_paddr_i,
  input  logic [NumReq*3-1:0]            req_pprot_i,
  input  logic [NumReq-1:0]              req_psel_i,
  input  logic [NumReq-1:0]              req_penable_i,
  input  logic [NumReq-1:0]              req_pwrite_i,
  input  logic [NumReq*DataWidth-1:0]    req_pwdata_i,
  input  logic [NumReq*StrbWidth-1:0]    req_pstrb_i,
  output logic [NumReq-1:0]              req_pready_o,
  output logic [NumReq*DataWidth-1:0]    req_prdata_o,
  output logic [NumReq-1:0]              req_pslverr_o,
  output logic [AddrWidth-1:0]           paddr_o,
  output logic [2:0]                     pprot_o,
  output logic                           psel_o,
  output logic                           penable_o,
  output logic                           pwrite_o,
  output logic [DataWidth-1:0]           pwdata_o,
  output logic [StrbWidth-1:0]           pstrb_o,
  input  logic                           pready_i,
  input  logic [DataWidth-1:0]           prdata_i,
  input  logic                           pslverr_i
);

  localparam int unsigned GntWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GntWidth-1:0] grant_q, grant_d;
  logic [GntWidth-1:0] rr_q, rr_d;

  logic                pick_valid;
  logic [GntWidth-1:0] pick_idx;
  logic [31:0]         rr_ext;
  logic                active;
  logic                resp_fire;

  // penable from requesters is not needed: psel alone marks a pending transfer
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

  assign rr_ext = 32'(rr_q);

  // First pending index at or above rr_q, otherwise wrap to the lowest pending index
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!pick_valid && req_psel_i[i] && (i >= rr_ext)) begin
        pick_valid = 1'b1;
        pick_idx   = GntWidth'(i);
      end
    end
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!pick_valid && req_psel_i[i]) begin
        pick_valid = 1'b1;
        pick_idx   = GntWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d = IDLE;
          if (grant_q == GntWidth'(NumReq - 1)) begin
            rr_d = '0;
          end else begin
            rr_d = grant_q + GntWidth'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset suppresses everything in the cycle it is asserted so an aborted transfer never responds
  assign active    = !rst_i && (state_q != IDLE);
  assign resp_fire = !rst_i && (state_q == ACCESS) && pready_i;

  always_comb begin
    paddr_o   = '0;
    pprot_o   = '0;
    psel_o    = 1'b0;
    penable_o = 1'b0;
    pwrite_o  = 1'b0;
    pwdata_o  = '0;
    pstrb_o   = '0;
    if (active) begin
      psel_o    = 1'b1;
      penable_o = (state_q == ACCESS);
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (grant_q == GntWidth'(i)) begin
          paddr_o  = req_paddr_i[i*AddrWidth +: AddrWidth];
          pprot_o  = req_pprot_i[i*3 +: 3];
          pwrite_o = req_pwrite_i[i];
          pwdata_o = req_pwdata_i[i*DataWidth +: DataWidth];
          pstrb_o  = req_pstrb_i[i*StrbWidth +: StrbWidth];
        end
      end
    end
  end

  always_comb begin
    req_pready_o  = '0;
    req_prdata_o  = '0;
    req_pslverr_o = '0;
    if (resp_fire) begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (grant_q == GntWidth'(i)) begin
          req_pready_o[i]                         = 1'b1;
          req_prdata_o[i*DataWidth +: DataWidth]  = prdata_i;
          req_pslverr_o[i]                        = pslverr_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter with three requesters.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
    end \
  end

module tb_apb_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_i;
  logic [N*AW-1:0]   req_paddr;
  logic [N*3-1:0]    req_pprot;
  logic [N-1:0]      req_psel;
  logic [N-1:0]      req_penable;
  logic [N-1:0]      req_pwrite;
  logic [N*DW-1:0]   req_pwdata;
  logic [N*SW-1:0]   req_pstrb;
  logic [N-1:0]      req_pready;
  logic [N*DW-1:0]   req_prdata;
  logic [N-1:0]      req_pslverr;
  logic [AW-1:0]     paddr_o;
  logic [2:0]        pprot_o;
  logic              psel_o;
  logic              penable_o;
  logic              pwrite_o;
  logic [DW-1:0]     pwdata_o;
  logic [SW-1:0]     pstrb_o;
  logic              pready_i;
  logic [DW-1:0]     prdata_i;
  logic              pslverr_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr [3] = '{32'h1000, 32'h3000, 32'h2200};

  apb_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_paddr_i  (req_paddr),
    .req_pprot_i  (req_pprot),
    .req_psel_i   (req_psel),
    .req_penable_i(req_penable),
    .req_pwrite_i (req_pwrite),
    .req_pwdata_i (req_pwdata),
    .req_pstrb_i  (req_pstrb),
    .req_pready_o (req_pready),
    .req_prdata_o (req_prdata),
    .req_pslverr_o(req_pslverr),
    .paddr_o      (paddr_o),
    .pprot_o      (pprot_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .pwdata_o     (pwdata_o),
    .pstrb_o      (pstrb_o),
    .pready_i     (pready_i),
    .prdata_i     (prdata_i),
    .pslverr_i    (pslverr_i)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // A downstream transfer must always belong to a requester still holding psel with that address
  always @(negedge clk) begin
    if (!rst_i && psel_o) begin
      automatic bit ok = 1'b0;
      for (int i = 0; i < N; i++)
        if (req_psel[i] && (req_paddr[i*AW +: AW] === paddr_o)) ok = 1'b1;
      assert (ok) else begin
        errors++;
        $error("FAIL protocol: granted requester dropped psel, paddr_o %0h", paddr_o);
      end
    end
  end

  initial begin
    rst_i       = 1'b1;
    req_paddr   = {32'h2200, 32'h3000, 32'h1000};
    req_pprot   = {3'd2, 3'd1, 3'd0};
    req_pwdata  = {32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    req_pstrb   = {4'h3, 4'hC, 4'hF};
    req_psel    = '0;
    req_penable = '0;
    req_pwrite  = '0;
    pready_i    = 1'b1;
    prdata_i    = '0;
    pslverr_i   = 1'b0;

    // reset state
    repeat (2) next();
    mid();
    `CHK("rst_psel", psel_o, 1'b0)
    `CHK("rst_penable", penable_o, 1'b0)
    `CHK("rst_paddr", paddr_o, 32'h0)
    `CHK("rst_req_pready", req_pready, 3'b000)
    `CHK("rst_req_prdata", req_prdata, 96'h0)
    next();
    rst_i = 1'b0;

    // single write from requester 0, zero wait states
    req_psel[0] = 1'b1; req_pwrite[0] = 1'b1;
    mid();
    `CHK("t1_idle_psel", psel_o, 1'b0)
    `CHK("t1_idle_paddr", paddr_o, 32'h0)
    next(); req_penable[0] = 1'b1; mid();
    `CHK("t1_setup_psel", psel_o, 1'b1)
    `CHK("t1_setup_penable", penable_o, 1'b0)
    `CHK("t1_setup_paddr", paddr_o, 32'h1000)
    `CHK("t1_setup_pwdata", pwdata_o, 32'hDEAD_BEEF)
    `CHK("t1_setup_pstrb", pstrb_o, 4'hF)
    `CHK("t1_setup_pwrite", pwrite_o, 1'b1)
    `CHK("t1_setup_no_ready", req_pready, 3'b000)
    next(); mid();
    `CHK("t1_access_penable", penable_o, 1'b1)
    `CHK("t1_access_pready", req_pready, 3'b001)
    next(); req_psel[0] = 1'b0; req_penable[0] = 1'b0; mid();
    `CHK("t1_after_psel", psel_o, 1'b0)
    `CHK("t1_after_pready", req_pready, 3'b000)

    // requesters 0 and 1 together from rr_q=0
    rst_i = 1'b1; next(); rst_i = 1'b0;
    req_psel[1:0] = 2'b11; req_pwrite[1:0] = 2'b11;
    mid();
    next(); mid();
    `CHK("t2_setup_r0", paddr_o, 32'h1000)
    next(); mid();
    `CHK("t2_done_r0", req_pready, 3'b001)
    next(); req_psel[0] = 1'b0; mid();
    `CHK("t2_gap_psel", psel_o, 1'b0)
    next(); mid();
    `CHK("t2_setup_r1", paddr_o, 32'h3000)
    `CHK("t2_setup_r1_penable", penable_o, 1'b0)
    next(); mid();
    `CHK("t2_done_r1", req_pready, 3'b010)
    next(); req_psel[1] = 1'b0;

    // slave error on requester 2 (rr_q=2), requester 0 also pending
    req_psel[2] = 1'b1; req_pwrite[2] = 1'b1; req_psel[0] = 1'b1; pslverr_i = 1'b1;
    mid(); next(); mid();
    `CHK("t4_setup_r2", paddr_o, 32'h2200)
    `CHK("t4_setup_pstrb", pstrb_o, 4'h3)
    `CHK("t4_setup_pprot", pprot_o, 3'd2)
    next(); mid();
    `CHK("t4_err", req_pslverr, 3'b100)
    `CHK("t4_err_ready", req_pready, 3'b100)
    next(); req_psel[2] = 1'b0; pslverr_i = 1'b0; mid();
    `CHK("t4_err_once", req_pslverr, 3'b000)
    next(); mid();
    `CHK("t4_setup_r0", paddr_o, 32'h1000)
    next(); mid();
    `CHK("t4_done_r0", req_pready, 3'b001)
    `CHK("t4_done_r0_err", req_pslverr, 3'b000)
    next(); req_psel[0] = 1'b0;

    // read from requester 1 with three wait states (rr_q=1)
    req_psel[1] = 1'b1; req_pwrite[1] = 1'b0; pready_i = 1'b0;
    mid(); next(); mid();
    `CHK("t3_setup_pwrite", pwrite_o, 1'b0)
    `CHK("t3_setup_paddr", paddr_o, 32'h3000)
    for (int w = 0; w < 3; w++) begin
      next(); mid();
      `CHK("t3_wait_pready", req_pready, 3'b000)
      `CHK("t3_wait_penable", penable_o, 1'b1)
    end
    next(); pready_i = 1'b1; prdata_i = 32'hA5A5_0001; mid();
    `CHK("t3_ready", req_pready, 3'b010)
    `CHK("t3_prdata", req_prdata, {32'h0, 32'hA5A5_0001, 32'h0})
    next(); req_psel[1] = 1'b0; prdata_i = 32'hFFFF_0000; mid();
    `CHK("t3_after_prdata", req_prdata, 96'h0)
    `CHK("t3_after_pready", req_pready, 3'b000)

    // all three continuously pending: order 0,1,2 repeating
    rst_i = 1'b1; next(); rst_i = 1'b0;
    req_pwrite = 3'b111; req_psel = 3'b111;
    for (int k = 0; k < 9; k++) begin
      mid();
      `CHK("t5_idle_psel", psel_o, 1'b0)
      next(); mid();
      `CHK("t5_setup_paddr", paddr_o, exp_addr[k % 3])
      next(); mid();
      `CHK("t5_grant", req_pready, 3'(1 << (k % 3)))
      next();
    end

    // reset during ACCESS with wait state; rr_q must return to 0
    req_psel[0] = 1'b0; pready_i = 1'b0;
    mid();
    next(); mid();
    `CHK("t6_setup_r1", paddr_o, 32'h3000)
    next(); rst_i = 1'b1; mid();
    next(); rst_i = 1'b0; mid();
    `CHK("t6_rst_psel", psel_o, 1'b0)
    `CHK("t6_rst_penable", penable_o, 1'b0)
    `CHK("t6_rst_pready", req_pready, 3'b000)
    pready_i = 1'b1;
    next(); mid();
    `CHK("t6_rr_after_rst", paddr_o, 32'h3000)
    `CHK("t6_setup_psel", psel_o, 1'b1)
    next(); mid();
    `CHK("t6_done_r1", req_pready, 3'b010)
    next(); req_psel = '0;
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
